// File: rtl/axi4_burst_wr_master.sv
// AXI4 INCR write-burst master: turns one command plus a beat stream into a
// single AW/W/B transaction and reports completion with the slave's response.
module axi4_burst_wr_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                        cmd_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  output logic                              done,
  output logic                              err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [7:0]                        m00_axi_awlen,
  output logic [2:0]                        m00_axi_awsize,
  output logic [1:0]                        m00_axi_awburst,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                              m00_axi_wlast,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready
);

  localparam int STRB_W   = C_M_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                          r_state;
  logic                            r_cmd_ready;
  logic                            r_awvalid;
  logic                            r_bready;
  logic                            r_done;
  logic                            r_err;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [7:0]                      r_awlen;
  logic [7:0]                      r_beat_cnt;

  logic                            w_in_data;
  logic                            w_wvalid;
  logic                            w_wready;
  logic                            w_last;
  logic                            w_w_hs;
  logic                            w_b_hs;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_addr_aligned;
  logic                            w_unused;

  // Only the error bit of BRESP and the beat-aligned address bits matter here.
  assign w_unused = &{1'b0, m00_axi_bresp[0], cmd_addr[ADDR_LSB-1:0]};

  // W channel is a straight pass-through gated to the DATA phase.
  always_comb begin
    w_in_data      = (r_state == ST_DATA);
    w_addr_aligned = {cmd_addr[C_M_AXI_ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
    if (w_in_data) begin
      w_wvalid = wr_valid;
      w_wready = m00_axi_wready;
      w_last   = (r_beat_cnt == r_awlen);
    end else begin
      w_wvalid = 1'b0;
      w_wready = 1'b0;
      w_last   = 1'b0;
    end
    w_w_hs = w_wvalid & w_wready;
    w_b_hs = m00_axi_bvalid & r_bready;
  end

  // Burst sequencer: IDLE -> ADDR -> DATA -> RESP -> IDLE, one burst in flight.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_awaddr    <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      r_awlen     <= 8'd0;
      r_beat_cnt  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_awaddr    <= w_addr_aligned;
            r_awlen     <= cmd_len;
            r_beat_cnt  <= 8'd0;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b1;
            r_state     <= ST_ADDR;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (r_awvalid && m00_axi_awready) begin
            r_awvalid <= 1'b0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            if (w_last) begin
              r_beat_cnt <= 8'd0;
              r_bready   <= 1'b1;
              r_state    <= ST_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= m00_axi_bresp[1];
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b0;
          r_awvalid   <= 1'b0;
          r_bready    <= 1'b0;
          r_beat_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign wr_ready        = w_wready;
  assign done            = r_done;
  assign err             = r_err;
  assign m00_axi_awaddr  = r_awaddr;
  assign m00_axi_awlen   = r_awlen;
  assign m00_axi_awsize  = 3'(ADDR_LSB);
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = wr_data;
  assign m00_axi_wstrb   = {STRB_W{1'b1}};
  assign m00_axi_wlast   = w_last;
  assign m00_axi_wvalid  = w_wvalid;
  assign m00_axi_bready  = r_bready;

endmodule

// File: tb/tb_axi4_burst_wr_master.sv
// Self-checking bench for axi4_burst_wr_master: directed table of bursts,
// randomized bursts against a transaction-level model, and reset/B corner cases.
module tb_axi4_burst_wr_master;

  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_addr = 6'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        done;
  logic        err;
  logic [5:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;

  int n_cmp = 0;
  int n_mis = 0;

  axi4_burst_wr_master #(.C_M_AXI_ADDR_WIDTH(6), .C_M_AXI_DATA_WIDTH(32)) dut (
    .m00_axi_aclk(clk), .m00_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .done(done), .err(err),
    .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
    .m00_axi_awburst(awburst), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [7:0]  len;
    logic [1:0]  bresp;
    int          aw_stall;
    bit          rnd;
    logic [31:0] data;        // 0 selects random beat data
    logic [5:0]  exp_awaddr;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete burst; the expected behaviour comes from transaction-level
  // bookkeeping: which handshakes have happened and how many beats went out.
  task automatic run_burst(input vec_t v);
    logic [31:0] q[$];
    int  beats = 0;
    int  aw_cycles = 0;
    int  cyc = 0;
    bit  cmd_sent = 1'b0;
    bit  aw_done = 1'b0;
    bit  b_done = 1'b0;
    bit  fin = 1'b0;
    bit  in_data;
    for (int i = 0; i <= int'(v.len); i++) q.push_back((v.data != 32'd0) ? v.data : $urandom);
    while (!fin && cyc < BUDGET) begin
      tick();
      cmd_valid = !cmd_sent;
      cmd_addr  = v.addr;
      cmd_len   = v.len;
      awready   = (aw_cycles >= v.aw_stall) && (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      wr_valid  = (beats <= int'(v.len)) && (v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      wr_data   = (beats <= int'(v.len)) ? q[beats] : $urandom;
      wready    = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bvalid    = (beats > int'(v.len)) && !b_done && (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      bresp     = v.bresp;
      @(negedge clk);
      cyc++;
      in_data = aw_done && (beats <= int'(v.len));
      chk("done", done, b_done);
      if (b_done) begin
        chk("err", err, v.exp_err);
        fin = 1'b1;
      end
      if (cmd_sent) chk("cmd_ready_busy", cmd_ready, 1'b0);
      chk("awvalid", awvalid, cmd_sent && !aw_done);
      if (awvalid) begin
        chk("awaddr", awaddr, v.exp_awaddr);
        chk("awlen", awlen, v.len);
        chk("awsize", awsize, 3'd2);
        chk("awburst", awburst, 2'b01);
      end
      chk("wvalid", wvalid, in_data ? wr_valid : 1'b0);
      chk("wr_ready", wr_ready, in_data ? wready : 1'b0);
      chk("bready", bready, (beats > int'(v.len)) && !b_done);
      if (cmd_valid && cmd_ready) cmd_sent = 1'b1;
      if (awvalid) aw_cycles++;
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) begin
        chk("wdata", wdata, q[beats]);
        chk("wlast", wlast, beats == int'(v.len));
        chk("wstrb", wstrb, 4'hF);
        beats++;
      end
      if (bvalid && bready) b_done = 1'b1;
    end
    if (!fin) begin
      n_cmp++;
      n_mis++;
      $display("FAIL burst_timeout: no done after %0d cycles, expected done", cyc);
    end
    chk("beat_count", beats, int'(v.len) + 1);
    if (!v.rnd) chk("aw_cycles", aw_cycles, v.aw_stall + 1);
    tick();
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    bvalid    = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_done", cmd_ready, 1'b1);
    chk("done_single_cycle", done, 1'b0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] d0;
    logic [31:0] d1;

    tbl[0] = '{6'h10, 8'd3,  2'b00, 0, 1'b0, 32'h0,        6'h10, 1'b0};
    tbl[1] = '{6'h00, 8'd0,  2'b00, 0, 1'b0, 32'hA5A5A5A5, 6'h00, 1'b0};
    tbl[2] = '{6'h24, 8'd2,  2'b00, 5, 1'b0, 32'h0,        6'h24, 1'b0};
    tbl[3] = '{6'h08, 8'd7,  2'b00, 0, 1'b1, 32'h0,        6'h08, 1'b0};
    tbl[4] = '{6'h13, 8'd1,  2'b10, 0, 1'b0, 32'h0,        6'h10, 1'b1};
    tbl[5] = '{6'h3F, 8'd0,  2'b11, 2, 1'b1, 32'h0,        6'h3C, 1'b1};
    tbl[6] = '{6'h20, 8'd15, 2'b01, 1, 1'b1, 32'h0,        6'h20, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    tick();
    areset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_before_rise", cmd_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("cmd_ready_rise", cmd_ready, 1'b1);

    // B response outside RESP must be ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      bvalid = 1'b1;
      bresp  = 2'b10;
      @(negedge clk);
      chk("idle_bready", bready, 1'b0);
      chk("idle_done", done, 1'b0);
    end
    tick();
    bvalid = 1'b0;

    for (int i = 0; i < 7; i++) run_burst(tbl[i]);

    // Randomized bursts; model: address rounded down to a beat, err = BRESP[1]
    for (int i = 0; i < 20; i++) begin
      v.addr       = 6'($urandom);
      v.len        = 8'($urandom_range(0, 31));
      v.bresp      = 2'($urandom);
      v.aw_stall   = $urandom_range(0, 3);
      v.rnd        = 1'b1;
      v.data       = 32'd0;
      v.exp_awaddr = 6'((int'(v.addr) / 4) * 4);
      v.exp_err    = (v.bresp >= 2'd2);
      run_burst(v);
    end

    // Reset on the second beat of a 4-beat burst
    d0 = $urandom;
    d1 = $urandom;
    tick();
    cmd_valid = 1'b1; cmd_addr = 6'h08; cmd_len = 8'd3; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    chk("mr_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mr_awvalid", awvalid, 1'b1);
    tick();
    wr_valid = 1'b1; wr_data = d0;
    @(negedge clk);
    chk("mr_beat0_wdata", wdata, d0);
    chk("mr_beat0_wvalid", wvalid, 1'b1);
    tick();
    wr_data = d1; areset = 1'b1;
    @(negedge clk);
    chk("mr_beat1_wlast", wlast, 1'b0);
    tick();
    @(negedge clk);
    chk("mr_awvalid_rst", awvalid, 1'b0);
    chk("mr_wvalid_rst", wvalid, 1'b0);
    chk("mr_bready_rst", bready, 1'b0);
    chk("mr_cmd_ready_rst", cmd_ready, 1'b0);
    chk("mr_done_rst", done, 1'b0);
    tick();
    @(negedge clk);
    chk("mr_done_hold", done, 1'b0);
    tick();
    areset = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("mr_cmd_ready_rel", cmd_ready, 1'b0);
    chk("mr_done_rel", done, 1'b0);
    tick();
    @(negedge clk);
    chk("mr_cmd_ready_up", cmd_ready, 1'b1);
    v = tbl[0];
    run_burst(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
